// File: rtl/aire_pkg.sv
// Shared encodings for the air-conditioner fan path: FSM states, speed codes, default duties.
// Constants only; no logic, no latency, no flow control.
package aire_pkg;

   typedef enum logic [1:0] {
      ST_OFF  = 2'b00,
      ST_KICK = 2'b01,
      ST_RAMP = 2'b10,
      ST_RUN  = 2'b11
   } fan_state_t;

   localparam logic [1:0] VEL_OFF  = 2'b00;
   localparam logic [1:0] VEL_LOW  = 2'b01;
   localparam logic [1:0] VEL_MED  = 2'b10;
   localparam logic [1:0] VEL_HIGH = 2'b11;

   localparam int DEF_DUTY_LOW  = 64;
   localparam int DEF_DUTY_MED  = 160;
   localparam int DEF_DUTY_HIGH = 255;

endpackage

// File: rtl/pwm_timebase.sv
// PWM timebase: prescaler, period counter, tick and period_end strobes (combinational from flops).
// Free-running, no backpressure; period = PRESCALE * 2^PWM_W clocks.
module pwm_timebase #(
   parameter int PWM_W    = 8,
   parameter int PRESCALE = 4
) (
   input  logic             clock,
   input  logic             reset,
   output logic [PWM_W-1:0] cnt,
   output logic             tick,
   output logic             period_end
);

   localparam int PS_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;

   logic [PS_W-1:0]  presc_q, presc_d;
   logic [PWM_W-1:0] cnt_q, cnt_d;

   always_comb begin
      tick       = (presc_q == PS_W'(PRESCALE - 1));
      period_end = tick && (cnt_q == '1);
      presc_d    = tick ? '0 : presc_q + PS_W'(1);
      cnt_d      = tick ? cnt_q + PWM_W'(1) : cnt_q;
      cnt        = cnt_q;
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         presc_q <= '0;
         cnt_q   <= '0;
      end else begin
         presc_q <= presc_d;
         cnt_q   <= cnt_d;
      end
   end

endmodule

// File: rtl/vent_pwm_driver.sv
// Fan PWM driver: kick-start at full duty, then linear ramp to the speed target; updates only at period ends.
// Inputs act at the next period boundary (up to one period); pwm_out lags cnt by one clock; no backpressure.
module vent_pwm_driver
   import aire_pkg::*;
#(
   parameter int PWM_W        = 8,
   parameter int PRESCALE     = 4,
   parameter int KICK_PERIODS = 4,
   parameter int RAMP_STEP    = 8,
   parameter int DUTY_LOW     = DEF_DUTY_LOW,
   parameter int DUTY_MED     = DEF_DUTY_MED,
   parameter int DUTY_HIGH    = DEF_DUTY_HIGH
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             enable,
   input  logic [1:0]       speed,
   output logic             pwm_out,
   output logic [PWM_W-1:0] duty,
   output logic [1:0]       state,
   output logic             at_target
);

   localparam int KW = (KICK_PERIODS > 1) ? $clog2(KICK_PERIODS) : 1;
   localparam logic [PWM_W-1:0] DMAX = '1;

   logic [PWM_W-1:0] cnt;
   logic             tick;
   logic             period_end;

   pwm_timebase #(
      .PWM_W    (PWM_W),
      .PRESCALE (PRESCALE)
   ) u_timebase (
      .clock      (clock),
      .reset      (reset),
      .cnt        (cnt),
      .tick       (tick),
      .period_end (period_end)
   );

   fan_state_t       state_q, state_d;
   logic [PWM_W-1:0] duty_q, duty_d;
   logic [KW-1:0]    kick_q, kick_d;
   logic             pwm_q, pwm_d;
   logic             at_target_q, at_target_d;

   logic [PWM_W-1:0] target;
   logic [PWM_W:0]   duty_x, tgt_x, step_x, up_x;
   logic [PWM_W-1:0] stepped;

   always_comb begin
      target = '0;
      if (enable) begin
         unique case (speed)
            VEL_LOW:  target = PWM_W'(DUTY_LOW);
            VEL_MED:  target = PWM_W'(DUTY_MED);
            VEL_HIGH: target = PWM_W'(DUTY_HIGH);
            default:  target = '0;
         endcase
      end
   end

   // One extra bit so the step can be compared against the target without wrapping.
   always_comb begin
      duty_x  = {1'b0, duty_q};
      tgt_x   = {1'b0, target};
      step_x  = (PWM_W + 1)'(RAMP_STEP);
      up_x    = duty_x + step_x;
      stepped = duty_q;
      if (duty_x < tgt_x) begin
         stepped = (up_x >= tgt_x) ? target : up_x[PWM_W-1:0];
      end else if (duty_x > tgt_x) begin
         stepped = (duty_x <= tgt_x + step_x) ? target : duty_q - PWM_W'(RAMP_STEP);
      end
   end

   always_comb begin
      state_d = state_q;
      duty_d  = duty_q;
      kick_d  = kick_q;
      if (period_end) begin
         unique case (state_q)
            ST_OFF: begin
               duty_d = '0;
               if (target != '0) begin
                  state_d = ST_KICK;
                  kick_d  = KW'(KICK_PERIODS - 1);
                  duty_d  = DMAX;
               end
            end
            ST_KICK: begin
               duty_d = DMAX;
               if (target == '0 || kick_q == '0) state_d = ST_RAMP;
               else                              kick_d  = kick_q - KW'(1);
            end
            ST_RAMP: begin
               duty_d = stepped;
               if (stepped == target) state_d = (target == '0) ? ST_OFF : ST_RUN;
            end
            ST_RUN: begin
               if (target != duty_q) begin
                  duty_d  = stepped;
                  state_d = ST_RAMP;
               end
            end
            default: state_d = ST_OFF;
         endcase
      end
      pwm_d       = (duty_q == DMAX) || (cnt < duty_q);
      at_target_d = (state_d == ST_RUN);
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_q     <= ST_OFF;
         duty_q      <= '0;
         kick_q      <= '0;
         pwm_q       <= 1'b0;
         at_target_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         duty_q      <= duty_d;
         kick_q      <= kick_d;
         pwm_q       <= pwm_d;
         at_target_q <= at_target_d;
      end
   end

   assign pwm_out   = pwm_q;
   assign duty      = duty_q;
   assign state     = state_q;
   assign at_target = at_target_q;

endmodule

// File: tb/tb_vent_pwm_driver.sv
// Bench for vent_pwm_driver: directed scenarios plus random inputs, every cycle compared to a period-level model.
module tb_vent_pwm_driver;

   localparam int PWM_W    = 8;
   localparam int PRESCALE = 1;
   localparam int KICKP    = 2;
   localparam int STEP     = 32;
   localparam int D_LOW    = 64;
   localparam int D_MED    = 160;
   localparam int D_HIGH   = 255;
   localparam int PER      = PRESCALE * (1 << PWM_W);
   localparam int MAXD     = (1 << PWM_W) - 1;
   localparam int S_OFF = 0, S_KICK = 1, S_RAMP = 2, S_RUN = 3;

   logic             clock = 1'b0;
   logic             reset = 1'b0;
   logic             enable = 1'b0;
   logic [1:0]       speed = 2'b00;
   logic             pwm_out;
   logic [PWM_W-1:0] duty;
   logic [1:0]       state;
   logic             at_target;

   vent_pwm_driver #(
      .PWM_W        (PWM_W),
      .PRESCALE     (PRESCALE),
      .KICK_PERIODS (KICKP),
      .RAMP_STEP    (STEP),
      .DUTY_LOW     (D_LOW),
      .DUTY_MED     (D_MED),
      .DUTY_HIGH    (D_HIGH)
   ) dut (
      .clock     (clock),
      .reset     (reset),
      .enable    (enable),
      .speed     (speed),
      .pwm_out   (pwm_out),
      .duty      (duty),
      .state     (state),
      .at_target (at_target)
   );

   always #5 clock = ~clock;

   int total = 0;
   int bad   = 0;

   // Model: clocks since reset release, fan state, applied duty, kick periods left, expected pwm.
   int m_n = 0, m_st = S_OFF, m_duty = 0, m_kick = 0, m_pwm = 0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      if (obs !== exp) begin
         bad++;
         $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, obs, exp, $time);
      end
   endtask

   function automatic int target_of(input logic en, input logic [1:0] sp);
      if (!en) return 0;
      case (sp)
         2'd1:    return D_LOW;
         2'd2:    return D_MED;
         2'd3:    return D_HIGH;
         default: return 0;
      endcase
   endfunction

   function automatic int move_toward(input int d, input int t);
      if (d < t) return (d + STEP > t) ? t : d + STEP;
      if (d > t) return (d - STEP < t) ? t : d - STEP;
      return d;
   endfunction

   task automatic model_reset();
      m_n = 0; m_st = S_OFF; m_duty = 0; m_kick = 0; m_pwm = 0;
   endtask

   task automatic model_edge();
      int pos, t;
      if (reset) begin
         model_reset();
         return;
      end
      pos   = m_n % PER;
      m_pwm = (m_duty == MAXD || (pos / PRESCALE) < m_duty) ? 1 : 0;
      if (pos == PER - 1) begin
         t = target_of(enable, speed);
         case (m_st)
            S_OFF: if (t != 0) begin m_st = S_KICK; m_kick = KICKP - 1; m_duty = MAXD; end
            S_KICK: begin
               if (t == 0 || m_kick == 0) m_st = S_RAMP;
               else m_kick--;
            end
            S_RAMP: begin
               m_duty = move_toward(m_duty, t);
               if (m_duty == t) m_st = (t == 0) ? S_OFF : S_RUN;
            end
            default: if (t != m_duty) begin m_duty = move_toward(m_duty, t); m_st = S_RAMP; end
         endcase
      end
      m_n++;
   endtask

   task automatic check_outs(input string tag);
      logic [11:0] exp;
      exp = {2'(m_st), (m_st == S_RUN), 8'(m_duty), (m_pwm != 0)};
      chk(tag, {20'd0, state, at_target, duty, pwm_out}, {20'd0, exp});
   endtask

   task automatic cycle();
      @(posedge clock);
      model_edge();
      #1;
      check_outs("outs");
      @(negedge clock);
   endtask

   task automatic to_boundary();
      int g = 0;
      cycle();
      while ((m_n % PER) != 0 && g < 2 * PER) begin
         cycle();
         g++;
      end
      if (g >= 2 * PER) chk("boundary_timeout", 1, 0);
   endtask

   task automatic seq_check(input string tag, input int ed[$], input int es[$]);
      foreach (ed[i]) begin
         to_boundary();
         chk($sformatf("%s_duty%0d", tag, i), 32'(duty), ed[i]);
         chk($sformatf("%s_state%0d", tag, i), 32'(state), es[i]);
      end
   endtask

   task automatic count_pwm(input string tag, input int exp);
      int n = 0;
      repeat (PER) begin
         cycle();
         n += int'(pwm_out);
      end
      chk(tag, n, exp);
   endtask

   task automatic do_reset(input int hold);
      reset = 1'b1;
      #1;
      model_reset();
      check_outs("rst_imm");
      chk("rst_zero", {28'd0, pwm_out, at_target, state}, 0);
      repeat (hold) cycle();
      reset = 1'b0;
   endtask

   initial begin
      #2;
      reset = 1'b1;
      #1;
      check_outs("por");
      @(negedge clock);
      repeat (2) cycle();
      reset = 1'b0;

      // Mid-period reset with inputs active, then quiet until the first boundary.
      repeat (100) cycle();
      enable = 1'b1;
      speed  = 2'b01;
      repeat (50) cycle();
      do_reset(3);
      repeat (PER - 1) cycle();
      chk("t1_still_off", {22'd0, state, duty}, 0);

      seq_check("t2", '{255, 255, 255, 223, 191, 159, 127, 95, 64}, '{1, 1, 2, 2, 2, 2, 2, 2, 3});
      chk("t2_at_target", 32'(at_target), 1);
      count_pwm("t2_pwm_high", 64);

      speed = 2'b11;
      seq_check("t3", '{96, 128, 160, 192, 224, 255}, '{2, 2, 2, 2, 2, 3});
      count_pwm("t3_pwm_high", PER);

      speed = 2'b10;
      seq_check("t4a", '{223, 191, 160}, '{2, 2, 3});
      enable = 1'b0;
      seq_check("t4b", '{128, 96, 64, 32, 0}, '{2, 2, 2, 2, 0});
      count_pwm("t4_pwm_high", 0);
      enable = 1'b1;
      seq_check("t4c", '{255}, '{1});

      speed = 2'b00;
      seq_check("t5a", '{255, 223, 191, 159, 127, 95, 63, 31, 0}, '{2, 2, 2, 2, 2, 2, 2, 2, 0});
      speed = 2'b01;
      seq_check("t5b", '{255, 255, 255, 223, 191, 159, 127, 95, 64}, '{1, 1, 2, 2, 2, 2, 2, 2, 3});
      repeat (40) cycle();
      speed = 2'b10;
      repeat (40) cycle();
      speed = 2'b01;
      seq_check("t5c", '{64}, '{3});

      enable = 1'b0;
      seq_check("t6a", '{32, 0}, '{2, 0});
      enable = 1'b1;
      seq_check("t6b", '{255, 255, 255, 223, 191, 159, 127}, '{1, 1, 2, 2, 2, 2, 2});
      repeat (60) cycle();
      speed = 2'b10;
      do_reset(2);
      repeat (PER - 1) cycle();
      seq_check("t6c", '{255, 255, 255, 223, 191, 160}, '{1, 1, 2, 2, 2, 3});

      repeat (40) begin
         enable = ($urandom_range(0, 3) != 0);
         speed  = 2'($urandom);
         if ($urandom_range(0, 9) == 0) do_reset($urandom_range(1, 5));
         repeat ($urandom_range(1, 3 * PER)) cycle();
         if ($urandom_range(0, 1) == 1) begin
            speed = 2'($urandom);
            repeat ($urandom_range(1, PER)) cycle();
         end
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
